param_up_down_counter: RTL and testbench

Parametrised synchronous up/down counter. It generalises the team's fixed 4-bit mod-16 up/down counter with configurable width, a runtime-programmable terminal limit, and a parallel load. It also adds a separate count enable, selectable wrap or saturate mode, and terminal-count and rollover flags. It is used as the general-purpose counting primitive in the counters library, for timers, address generators and event tallies.

---
 rtl/param_up_down_counter.sv | 111 +++++++++++
 tb/tb_param_up_down_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with a programmable limit, parallel load, wrap or
// saturate at the range ends, a cascade terminal count, and rollover/at_bound flags.
module param_up_down_counter #(
  parameter int unsigned       WIDTH       = 4,
  parameter bit                SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             count_en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             rollover,
  output logic             at_bound
);

  if (WIDTH < 2) begin : g_bad_width
    $error("param_up_down_counter: WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_DEC,
    ACT_TO_ZERO,
    ACT_TO_LIMIT,
    ACT_BLOCK
  } action_e;

  action_e          action;
  logic             wrapped;
  logic             at_top;
  logic             at_zero;
  logic             above;
  logic [WIDTH-1:0] step_count;
  logic [WIDTH-1:0] load_clamped;

  assign at_top       = (count == limit);
  assign at_zero      = (count == '0);
  assign above        = (count > limit);
  assign load_clamped = (load_value > limit) ? limit : load_value;

  // An out-of-range count (limit lowered at runtime) is re-entered before the
  // usual boundary rules apply; only the wrap-mode up step counts as a wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    action  = ACT_HOLD;
    wrapped = 1'b0;
    if (count_en) begin
      if (up_down) begin
        if (above) begin
          action  = SATURATE ? ACT_TO_LIMIT : ACT_TO_ZERO;
          wrapped = !SATURATE;
        end else if (at_top) begin
          action  = SATURATE ? ACT_BLOCK : ACT_TO_ZERO;
          wrapped = !SATURATE;
        end else begin
          action  = ACT_INC;
        end
      end else begin
        if (above) begin
          action  = ACT_TO_LIMIT;
        end else if (at_zero) begin
          action  = SATURATE ? ACT_BLOCK : ACT_TO_LIMIT;
          wrapped = !SATURATE;
        end else begin
          action  = ACT_DEC;
        end
      end
    end
  end

  always_comb begin
    step_count = count;
    unique case (action)
      ACT_INC:      step_count = count + 1'b1;
      ACT_DEC:      step_count = count - 1'b1;
      ACT_TO_ZERO:  step_count = '0;
      ACT_TO_LIMIT: step_count = limit;
      default:      step_count = count;
    endcase
  end

  // Priority: clear > load > count_en > hold. at_bound holds while idle; rollover
  // is a single-cycle pulse, so it drops on any edge that does not wrap.
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (clear) begin
      count    <= RESET_VALUE;
      rollover <= 1'b0;
      at_bound <= 1'b0;
    end else if (load) begin
      count    <= load_clamped;
      rollover <= 1'b0;
      at_bound <= 1'b0;
    end else if (count_en) begin
      count    <= step_count;
      rollover <= wrapped && !SATURATE;
      at_bound <= SATURATE && (action == ACT_BLOCK);
    end else begin
      rollover <= 1'b0;
    end
  end

  assign tc = count_en & (up_down ? at_top : at_zero);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter: one wrap-mode and one saturate-mode
// instance, expected outputs queued by the stimulus and checked by a monitor.
module tb_param_up_down_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       w_clear, w_en, w_ud, w_load;
  logic [3:0] w_lv, w_lim, w_count;
  logic       w_tc, w_roll, w_bound;
  logic       s_clear, s_en, s_ud, s_load;
  logic [3:0] s_lv, s_lim, s_count;
  logic       s_tc, s_roll, s_bound;

  param_up_down_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(4'd0)) dut_w (
    .clock(clock), .clear(w_clear), .count_en(w_en), .up_down(w_ud), .load(w_load),
    .load_value(w_lv), .limit(w_lim), .count(w_count), .tc(w_tc),
    .rollover(w_roll), .at_bound(w_bound)
  );

  param_up_down_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(4'd5)) dut_s (
    .clock(clock), .clear(s_clear), .count_en(s_en), .up_down(s_ud), .load(s_load),
    .load_value(s_lv), .limit(s_lim), .count(s_count), .tc(s_tc),
    .rollover(s_roll), .at_bound(s_bound)
  );

  typedef struct {
    bit         sel;
    string      name;
    logic [3:0] c;
    logic       r;
    logic       b;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  localparam bit W = 1'b0;
  localparam bit S = 1'b1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One vector: drive the selected instance for one edge and queue the outputs
  // it must show just after that edge; the other instance is kept idle.
  task automatic v(input bit sel, input string nm,
                   input logic clr, input logic en, input logic ud, input logic ld,
                   input int lv, input int lim,
                   input int c, input logic r, input logic b, input logic t);
    exp_t e;
    @(negedge clock);
    if (sel == W) begin
      w_clear = clr; w_en = en; w_ud = ud; w_load = ld; w_lv = 4'(lv); w_lim = 4'(lim);
      s_clear = 1'b0; s_en = 1'b0; s_load = 1'b0;
    end else begin
      s_clear = clr; s_en = en; s_ud = ud; s_load = ld; s_lv = 4'(lv); s_lim = 4'(lim);
      w_clear = 1'b0; w_en = 1'b0; w_load = 1'b0;
    end
    e.sel = sel; e.name = nm; e.c = 4'(c); e.r = r; e.b = b; e.t = t;
    exp_q.push_back(e);
  endtask

  // Monitor: each queued entry belongs to the next rising edge.
  exp_t m;
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      if (m.sel == W) begin
        check({m.name, ".count"},    w_count,       m.c);
        check({m.name, ".rollover"}, {3'b0, w_roll},  {3'b0, m.r});
        check({m.name, ".at_bound"}, {3'b0, w_bound}, {3'b0, m.b});
        check({m.name, ".tc"},       {3'b0, w_tc},    {3'b0, m.t});
      end else begin
        check({m.name, ".count"},    s_count,       m.c);
        check({m.name, ".rollover"}, {3'b0, s_roll},  {3'b0, m.r});
        check({m.name, ".at_bound"}, {3'b0, s_bound}, {3'b0, m.b});
        check({m.name, ".tc"},       {3'b0, s_tc},    {3'b0, m.t});
      end
    end
  end

  initial begin
    w_clear = 1'b1; w_en = 1'b0; w_ud = 1'b1; w_load = 1'b0; w_lv = '0; w_lim = 4'd9;
    s_clear = 1'b1; s_en = 1'b0; s_ud = 1'b1; s_load = 1'b0; s_lv = '0; s_lim = 4'd5;

    // Wrap-mode instance.            clr en ud ld  lv lim   cnt r  b  t
    v(W, "w_rst0",                    1, 1, 1, 0,  0, 9,    0, 0, 0, 0);
    v(W, "w_rst1",                    1, 1, 1, 0,  0, 9,    0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      v(W, $sformatf("w_up%0d", i),   0, 1, 1, 0,  0, 9,    i, 0, 0, 0);
    v(W, "w_up9",                     0, 1, 1, 0,  0, 9,    9, 0, 0, 1);
    v(W, "w_wrap_up",                 0, 1, 1, 0,  0, 9,    0, 1, 0, 0);
    v(W, "w_up_after1",               0, 1, 1, 0,  0, 9,    1, 0, 0, 0);
    v(W, "w_up_after2",               0, 1, 1, 0,  0, 9,    2, 0, 0, 0);
    v(W, "w_ld2",                     0, 0, 1, 1,  2, 15,   2, 0, 0, 0);
    v(W, "w_dn1",                     0, 1, 0, 0,  0, 15,   1, 0, 0, 0);
    v(W, "w_dn0",                     0, 1, 0, 0,  0, 15,   0, 0, 0, 1);
    v(W, "w_wrap_dn",                 0, 1, 0, 0,  0, 15,  15, 1, 0, 0);
    v(W, "w_dn14",                    0, 1, 0, 0,  0, 15,  14, 0, 0, 0);
    v(W, "w_dir_up",                  0, 1, 1, 0,  0, 15,  15, 0, 0, 1);
    v(W, "w_ld_clamp",                0, 1, 1, 1, 12, 7,    7, 0, 0, 1);
    v(W, "w_clr_ld",                  1, 1, 1, 1, 12, 7,    0, 0, 0, 0);
    v(W, "w_ld12a",                   0, 0, 1, 1, 12, 15,  12, 0, 0, 0);
    v(W, "w_oor_up",                  0, 1, 1, 0,  0, 6,    0, 1, 0, 0);
    v(W, "w_ld12b",                   0, 0, 1, 1, 12, 15,  12, 0, 0, 0);
    v(W, "w_oor_dn",                  0, 1, 0, 0,  0, 6,    6, 0, 0, 0);
    v(W, "w_ld12c",                   0, 0, 1, 1, 12, 15,  12, 0, 0, 0);
    v(W, "w_oor_hold",                0, 0, 1, 0,  0, 6,   12, 0, 0, 0);
    v(W, "w_lim0_up_a",               0, 1, 1, 0,  0, 0,    0, 1, 0, 1);
    v(W, "w_lim0_up_b",               0, 1, 1, 0,  0, 0,    0, 1, 0, 1);
    v(W, "w_lim0_dn",                 0, 1, 0, 0,  0, 0,    0, 1, 0, 1);
    v(W, "w_lim0_idle",               0, 0, 0, 0,  0, 0,    0, 0, 0, 0);

    // Saturate-mode instance (reset value 5).
    v(S, "s_rst",                     1, 0, 1, 0,  0, 5,    5, 0, 0, 0);
    v(S, "s_ld3",                     0, 0, 1, 1,  3, 5,    3, 0, 0, 0);
    v(S, "s_up4",                     0, 1, 1, 0,  0, 5,    4, 0, 0, 0);
    v(S, "s_up5",                     0, 1, 1, 0,  0, 5,    5, 0, 0, 1);
    v(S, "s_block_a",                 0, 1, 1, 0,  0, 5,    5, 0, 1, 1);
    v(S, "s_block_b",                 0, 1, 1, 0,  0, 5,    5, 0, 1, 1);
    v(S, "s_block_c",                 0, 1, 1, 0,  0, 5,    5, 0, 1, 1);
    v(S, "s_idle_keep",               0, 0, 1, 0,  0, 5,    5, 0, 1, 0);
    v(S, "s_dn4",                     0, 1, 0, 0,  0, 5,    4, 0, 0, 0);
    v(S, "s_ld1",                     0, 0, 0, 1,  1, 5,    1, 0, 0, 0);
    v(S, "s_dn0",                     0, 1, 0, 0,  0, 5,    0, 0, 0, 1);
    v(S, "s_block_dn",                0, 1, 0, 0,  0, 5,    0, 0, 1, 1);
    v(S, "s_up_opp",                  0, 1, 1, 0,  0, 5,    1, 0, 0, 0);
    v(S, "s_ld_clamp",                0, 1, 1, 1, 12, 7,    7, 0, 0, 1);
    v(S, "s_block_7",                 0, 1, 1, 0,  0, 7,    7, 0, 1, 1);
    v(S, "s_ld_clr_bound",            0, 0, 1, 1,  7, 7,    7, 0, 0, 0);
    v(S, "s_ld12a",                   0, 0, 1, 1, 12, 15,  12, 0, 0, 0);
    v(S, "s_oor_up",                  0, 1, 1, 0,  0, 6,    6, 0, 0, 1);
    v(S, "s_ld12b",                   0, 0, 1, 1, 12, 15,  12, 0, 0, 0);
    v(S, "s_oor_dn",                  0, 1, 0, 0,  0, 6,    6, 0, 0, 0);
    v(S, "s_clr_ld",                  1, 1, 1, 1, 12, 7,    5, 0, 0, 0);
    v(S, "s_lim0_up_a",               0, 1, 1, 0,  0, 0,    0, 0, 0, 1);
    v(S, "s_lim0_up_b",               0, 1, 1, 0,  0, 0,    0, 0, 1, 1);
    v(S, "s_lim0_dn",                 0, 1, 0, 0,  0, 0,    0, 0, 1, 1);

    @(negedge clock);
    w_en = 1'b0; w_load = 1'b0; s_en = 1'b0; s_load = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
